fir_filter: RTL and testbench
=============================

Name: fir_filter

Overview:
Parameterised direct-form FIR filter with runtime-loadable coefficients and a valid-qualified sample stream. Each accepted 16-bit signed input sample produces one 32-bit signed output: the dot product of the coefficient set with the most recent FIR_ORDER samples. The filter sits in the signal-processing datapath between a sample source and a result consumer. It is fully pipelined, accepts one sample per clock and has a fixed latency.

Parameters:
FIR_ORDER, 4, number of taps (≥2); width of coeff_in is FIR_ORDER*16

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high; clears all state
load  in  1  coefficient load strobe; coeff_in captured on the rising edge where load=1
valid_in  in  1  signal_in carries a new sample this cycle
coeff_in  in  FIR_ORDER*16  packed coefficients; bits [16k+15:16k] = c[k], signed two's complement; c[0] multiplies the newest sample
signal_in  in  16  input sample x[n], signed two's complement
valid_out  out  1  one-cycle pulse: signal_out holds a new result
signal_out  out  32  filter result y[n], signed two's complement

Behaviour:
- Reset (rst=1 at a rising edge):
  - Clears coefficient registers, delay line, all pipeline registers and valid flags.
  - Drives signal_out=0 and valid_out=0.
  - rst has priority over load and valid_in.
  - Results of samples in flight when reset is applied are discarded; no valid_out is generated for them.
- Load: on a rising edge with load=1 (and rst=0), c[k] <= coeff_in slice k for all k.
  - Load does not clear the delay line or the pipeline.
  - A sample accepted on the same edge as a load is multiplied by the new coefficients.
  - Samples accepted earlier use the coefficients present at their product stage.
- Delay line: FIR_ORDER x 16-bit registers x[0..FIR_ORDER-1], all zero after reset.
  - On an edge with valid_in=1: x[0] <= signal_in and x[k] <= x[k-1].
  - On an edge with valid_in=0: the delay line holds its contents.
- Arithmetic: y[n] = sum over k of c[k]*x[n-k].
  - Each product is signed 16x16 -> 32 bits.
  - Sums are accumulated in 32 bits with wrap-around modulo 2^32; no saturation.
- Pipeline (sample accepted on edge N):
  - Edge N: delay line shifts.
  - Edge N+1: all FIR_ORDER products are registered.
  - Edge N+2: pairwise partial sums are registered; an odd final product passes through.
  - Edge N+3: the sum of all partial sums is registered into signal_out, and valid_out=1.
  - Fixed latency is 3 clocks from the accepting edge to valid_out; valid_out is high for exactly one cycle per accepted sample.
- Throughput: one sample per clock. Back-to-back valid_in produces back-to-back valid_out pulses in the same order.
- Between results, signal_out holds the last computed value; valid_out=0 on cycles with no new result.
- Before the first FIR_ORDER samples arrive, the missing history is treated as zero (cleared delay line).

Test Plan:
- Impulse:
  - Stimulus: rst for 2 cycles; load c={4,3,2,1} (c[0]=1 … c[3]=4); then samples 1,0,0,0,0, each as a single valid_in pulse spaced 4 cycles apart.
  - Required response: signal_out = 0x1, 0x2, 0x3, 0x4, 0x0. valid_out goes high exactly 3 edges after each accepting edge and lasts one cycle.
- Step, back-to-back:
  - Stimulus: same coefficients; valid_in held high for 5 consecutive cycles with x=1.
  - Required response: 5 consecutive valid_out cycles with outputs 1, 3, 6, 10, 10.
- Signed arithmetic:
  - Stimulus: c={0,0,0,0xFFFF}; x=0x0002, then x=0xFFFE.
  - Required response: outputs 0xFFFFFFFE, then 0x00000002.
- Wrap-around:
  - Stimulus: all c=0x8000; four samples of x=0x8000.
  - Required response: outputs 0x40000000, 0x80000000, 0xC0000000, 0x00000000 (the fourth sum wraps).
- Reload mid-stream:
  - Stimulus: after the impulse test delay line is {0,0,0,0}; load c={0,0,0,2} on the same edge as x=5.
  - Required response: output 0xA; delay-line contents are preserved across the load (verify with one following sample x=0 -> output 0).
- Reset mid-operation:
  - Stimulus: assert rst one cycle after a valid_in pulse.
  - Required response: no valid_out for the in-flight sample; signal_out=0 after the reset edge; coefficients read back as zero (x=7 then gives output 0 until the next load).

Source files
------------

// File: rtl/fir_filter.sv
// Direct-form FIR filter: delay line, registered products, pairwise partial sums,
// and a final adder tree into signal_out. Fixed three-clock latency, one sample per clock.
module fir_filter #(
  parameter int FIR_ORDER = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   valid_in,
  input  logic [FIR_ORDER*16-1:0] coeff_in,
  input  logic [15:0]            signal_in,
  output logic                   valid_out,
  output logic [31:0]            signal_out
);

  localparam int NPART = (FIR_ORDER + 1) / 2;

  logic [15:0] coef_q [FIR_ORDER];
  logic [15:0] x_q    [FIR_ORDER];
  logic [31:0] prod_d [FIR_ORDER];
  logic [31:0] prod_q [FIR_ORDER];
  logic [31:0] part_d [NPART];
  logic [31:0] part_q [NPART];
  logic [31:0] sum_d;
  logic [31:0] out_q;
  logic        vx_q;
  logic        vp_q;
  logic        vs_q;
  logic        vo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FIR_ORDER; k++) begin
        coef_q[k] <= '0;
        x_q[k]    <= '0;
      end
    end else begin
      if (load) begin
        for (int k = 0; k < FIR_ORDER; k++) begin
          coef_q[k] <= coeff_in[16*k +: 16];
        end
      end
      if (valid_in) begin
        x_q[0] <= signal_in;
        for (int k = 1; k < FIR_ORDER; k++) begin
          x_q[k] <= x_q[k-1];
        end
      end
    end
  end

  // Sign-extended 32x32 multiply: the low 32 bits equal the signed 16x16 product.
  always_comb begin
    for (int k = 0; k < FIR_ORDER; k++) begin
      prod_d[k] = {{16{coef_q[k][15]}}, coef_q[k]} * {{16{x_q[k][15]}}, x_q[k]};
    end
  end

  for (genvar i = 0; i < NPART; i++) begin : g_part
    if (2*i + 1 < FIR_ORDER) begin : g_pair
      assign part_d[i] = prod_q[2*i] + prod_q[2*i+1];
    end else begin : g_pass
      assign part_d[i] = prod_q[2*i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NPART; i++) begin
      sum_d = sum_d + part_q[i];
    end
  end

  // The valid bit travels alongside the data so each stage knows whether its contents are live.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FIR_ORDER; k++) begin
        prod_q[k] <= '0;
      end
      for (int i = 0; i < NPART; i++) begin
        part_q[i] <= '0;
      end
      out_q <= '0;
      vx_q  <= 1'b0;
      vp_q  <= 1'b0;
      vs_q  <= 1'b0;
      vo_q  <= 1'b0;
    end else begin
      for (int k = 0; k < FIR_ORDER; k++) begin
        prod_q[k] <= prod_d[k];
      end
      for (int i = 0; i < NPART; i++) begin
        part_q[i] <= part_d[i];
      end
      if (vs_q) begin
        out_q <= sum_d;
      end
      vx_q <= valid_in;
      vp_q <= vx_q;
      vs_q <= vp_q;
      vo_q <= vs_q;
    end
  end

  assign valid_out  = vo_q;
  assign signal_out = out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: a dot-product reference model feeds a scoreboard
// queue, and a separate monitor checks every result, its latency and the hold behaviour.
module tb_fir_filter;

  localparam int N = 4;

  typedef struct {
    logic [31:0] value;
    int          due;
  } expEntry;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic          validIn = 1'b0;
  logic [N*16-1:0] coeffIn = '0;
  logic [15:0]   signalIn = '0;
  logic          validOut;
  logic [31:0]   signalOut;

  expEntry     expQ[$];
  int          cyc = 0;
  bit          rstAtEdge = 1'b0;
  bit          done = 1'b0;
  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] lastOut = '0;

  int          coefM [N];
  int          histM [N];

  fir_filter #(.FIR_ORDER(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .valid_in  (validIn),
    .coeff_in  (coeffIn),
    .signal_in (signalIn),
    .valid_out (validOut),
    .signal_out(signalOut)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    rstAtEdge = rst;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  // Monitor: drops results of samples accepted before a reset edge, then checks the output.
  always @(negedge clk) begin
    expEntry e;
    if (rstAtEdge) begin
      while (expQ.size() > 0 && expQ[0].due - 3 <= cyc) void'(expQ.pop_front());
      lastOut = '0;
    end
    if (validOut) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_valid_out", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", signalOut, e.value);
        checkOutput("latency", 32'(cyc), 32'(e.due));
        lastOut = e.value;
      end
    end else begin
      checkOutput("hold", signalOut, lastOut);
      if (expQ.size() > 0 && expQ[0].due <= cyc) begin
        e = expQ.pop_front();
        checkOutput("missing_valid_out", 32'd0, 32'd1);
      end
    end
    if (done) begin
      checkOutput("drained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
    end
  end

  // Drives one cycle; the reference model applies a same-edge load before the sample.
  task automatic applyStimulus(input bit ld, input logic [N*16-1:0] cf, input bit v, input logic [15:0] x);
    int y;
    @(negedge clk);
    rst      = 1'b0;
    load     = ld;
    coeffIn  = cf;
    validIn  = v;
    signalIn = x;
    if (ld) begin
      for (int k = 0; k < N; k++) coefM[k] = int'($signed(cf[16*k +: 16]));
    end
    if (v) begin
      for (int k = N - 1; k > 0; k--) histM[k] = histM[k-1];
      histM[0] = int'($signed(x));
      y = 0;
      for (int k = 0; k < N; k++) y = y + coefM[k] * histM[k];
      expQ.push_back('{value: 32'(y), due: cyc + 4});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 16'h0);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rst     = 1'b1;
    load    = 1'b0;
    validIn = 1'b0;
    for (int k = 0; k < N; k++) begin
      coefM[k] = 0;
      histM[k] = 0;
    end
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  localparam logic [N*16-1:0] C4321 = {16'd4, 16'd3, 16'd2, 16'd1};

  initial begin
    for (int k = 0; k < N; k++) begin
      coefM[k] = 0;
      histM[k] = 0;
    end
    doReset(2);
    applyStimulus(1'b1, C4321, 1'b0, 16'h0);

    // Impulse, widely spaced.
    applyStimulus(1'b0, '0, 1'b1, 16'd1);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 16'd0);
      idle(3);
    end

    // Step, back-to-back.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 16'd1);
    idle(4);

    // Signed arithmetic.
    applyStimulus(1'b1, {16'h0, 16'h0, 16'h0, 16'hFFFF}, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 16'h0);
    applyStimulus(1'b0, '0, 1'b1, 16'h0002);
    applyStimulus(1'b0, '0, 1'b1, 16'hFFFE);
    idle(4);

    // Wrap-around of the 32-bit accumulation.
    applyStimulus(1'b1, {4{16'h8000}}, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 16'h8000);
    idle(4);

    // Reload on the same edge as a sample, history preserved.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 16'h0);
    applyStimulus(1'b1, {16'h0, 16'h0, 16'h0, 16'h2}, 1'b1, 16'd5);
    applyStimulus(1'b0, '0, 1'b1, 16'd0);
    applyStimulus(1'b1, C4321, 1'b1, 16'd3);
    applyStimulus(1'b0, '0, 1'b1, 16'd0);
    idle(4);

    // Reset one cycle after a sample; coefficients must read back as zero.
    applyStimulus(1'b0, '0, 1'b1, 16'd9);
    doReset(1);
    applyStimulus(1'b0, '0, 1'b1, 16'd7);
    idle(5);

    // Randomised traffic with occasional reloads and one reset.
    applyStimulus(1'b1, {$urandom(), $urandom()}, 1'b0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset(1 + int'($urandom_range(0, 2)));
      applyStimulus(($urandom_range(0, 7) == 0), {$urandom(), $urandom()},
                    ($urandom_range(0, 3) != 0), 16'($urandom()));
    end
    idle(6);
    done = 1'b1;
  end

endmodule
